// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates one byte-wide RAM port between instruction fetch and the MEM stage,
//   splitting 1/2/4-byte accesses into little-endian byte beats.
// Latency: read done at grant+N+1 edges, write done at grant+N edges (N = byte count).
// Backpressure: requesters hold req until their done pulse; MEM beats IF, no preemption;
//   IF may drop req mid-fetch to flush, MEM accesses always run to completion.
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   if_req/if_addr      4-byte fetch request; if_done pulses with if_data valid
//   mem_req/mem_we/mem_len/mem_addr/mem_wdata   load/store request; mem_done pulses,
//                       mem_rdata valid for loads (bytes beyond length are zero)
//   ram_addr/ram_wr/ram_dout   registered RAM command; ram_din = byte at previous ram_addr
//   busy                high whenever an access is in progress
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_IF_RD  = 2'd1,
    S_MEM_RD = 2'd2,
    S_MEM_WR = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;        // reads: edges since grant minus one; writes: next byte index
  logic [2:0]  r_len;        // byte count of the access in flight
  logic [31:0] r_data;       // read assembly register, cleared at grant

  logic        w_grant_mem;
  logic        w_grant_if;
  logic        w_flush;
  logic        w_last;
  logic [2:0]  w_mem_len_n;
  logic [1:0]  w_byte_idx;
  logic [31:0] w_data_merged;

  assign w_mem_len_n   = (mem_len == 2'b00) ? 3'd1 :
                         (mem_len == 2'b01) ? 3'd2 : 3'd4;
  assign w_last        = (r_cnt == r_len);
  // Byte arriving on ram_din now belongs to slot cnt-1 (two-edge address-to-data delay).
  assign w_byte_idx    = 2'(r_cnt - 3'd1);
  assign w_data_merged = r_data | ({24'd0, ram_din} << {w_byte_idx, 3'b000});
  assign busy          = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_mem = 1'b0;
    w_grant_if  = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A requester still seeing its done pulse is dropping req this cycle; skip it.
        if (mem_req && !mem_done) begin
          w_grant_mem = 1'b1;
          w_state_nxt = mem_we ? S_MEM_WR : S_MEM_RD;
        end else if (if_req && !if_done) begin
          w_grant_if  = 1'b1;
          w_state_nxt = S_IF_RD;
        end
      end
      S_IF_RD: begin
        if (!if_req) begin
          w_flush     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MEM_RD, S_MEM_WR: begin
        if (w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= 3'd0;
      r_len     <= 3'd0;
      r_data    <= 32'd0;
      if_done   <= 1'b0;
      if_data   <= 32'd0;
      mem_done  <= 1'b0;
      mem_rdata <= 32'd0;
      ram_addr  <= '0;
      ram_wr    <= 1'b0;
      ram_dout  <= 8'd0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_mem) begin
            ram_addr <= mem_addr;
            r_len    <= w_mem_len_n;
            r_data   <= 32'd0;
            if (mem_we) begin
              // First write beat goes out on the grant edge itself.
              ram_wr   <= 1'b1;
              ram_dout <= mem_wdata[7:0];
              r_cnt    <= 3'd1;
            end else begin
              ram_wr   <= 1'b0;
              r_cnt    <= 3'd0;
            end
          end else if (w_grant_if) begin
            ram_addr <= if_addr;
            r_len    <= 3'd4;
            r_data   <= 32'd0;
            ram_wr   <= 1'b0;
            r_cnt    <= 3'd0;
          end
        end
        S_IF_RD, S_MEM_RD: begin
          // A flush simply abandons the access; any byte on ram_din is dropped.
          if (!w_flush) begin
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt < r_len - 3'd1) ram_addr <= ram_addr + ADDR_W'(1);
            if (r_cnt != 3'd0)        r_data   <= w_data_merged;
            if (w_last) begin
              if (r_state == S_IF_RD) begin
                if_data <= w_data_merged;
                if_done <= 1'b1;
              end else begin
                mem_rdata <= w_data_merged;
                mem_done  <= 1'b1;
              end
            end
          end
        end
        S_MEM_WR: begin
          if (w_last) begin
            ram_wr   <= 1'b0;
            mem_done <= 1'b1;
          end else begin
            ram_addr <= ram_addr + ADDR_W'(1);
            ram_dout <= mem_wdata[{r_cnt[1:0], 3'b000} +: 8];
            r_cnt    <= r_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed table, corner-case sequences and random traffic for mem_ctrl,
//   checked against a byte-array memory model and access-latency formulas.
module tb_mem_ctrl;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_done;
  logic [31:0]   if_data;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [1:0]    mem_len = 2'd0;
  logic [AW-1:0] mem_addr = '0;
  logic [31:0]   mem_wdata = 32'd0;
  logic          mem_done;
  logic [31:0]   mem_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_wr;
  logic [7:0]    ram_dout;
  logic [7:0]    ram_din = 8'd0;
  logic          busy;

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Environment RAM: synchronous read of the address seen at the edge, byte write on ram_wr.
  logic [7:0] ram    [0:(1<<AW)-1];
  // Reference memory image, updated only from the requests the bench issues.
  logic [7:0] shadow [0:(1<<AW)-1];

  always @(posedge clk) begin
    ram_din <= ram[ram_addr];
    if (ram_wr) ram[ram_addr] <= ram_dout;
  end

  int if_done_cnt  = 0;
  int mem_done_cnt = 0;
  always @(negedge clk) begin
    if (if_done)  if_done_cnt++;
    if (mem_done) mem_done_cnt++;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [AW-1:0] a, input int n);
    logic [31:0] r = 32'd0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = shadow[AW'(a + AW'(k))];
    return r;
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input int n, input logic [31:0] d);
    for (int k = 0; k < n; k++) shadow[AW'(a + AW'(k))] = d[8*k +: 8];
  endtask

  // Issues one request at a negedge, counts rising edges until its done is seen, releases req.
  task automatic run_op(input logic is_if, input logic we, input logic [1:0] len,
                        input logic [AW-1:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int edges);
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wd;
    end
    edges = 0;
    while (edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (is_if ? if_done : mem_done) break;
    end
    rd = is_if ? if_data : mem_rdata;
    if_req = 1'b0;
    mem_req = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic          is_if;
    logic          we;
    logic [1:0]    len;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   exp_data;
    int            exp_edges;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [31:0] rd;
    int          edges;
    int          snap;

    // Timeout guard for the whole run.
    fork
      begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
      end
    join_none

    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = 8'd0;
      shadow[i] = 8'd0;
    end
    for (int i = 0; i < 4; i++) begin
      ram[17'h100 + i] = 8'(i);
      shadow[17'h100 + i] = 8'(i);
    end
    for (int i = 0; i < 16; i++) begin
      ram[17'h500 + i] = 8'($urandom);
      shadow[17'h500 + i] = ram[17'h500 + i];
    end

    //            is_if we   len    addr       wdata         exp_data      edges
    vecs[0]  = '{1'b1, 1'b0, 2'd2, 17'h00100, 32'h0,        32'h03020100, 6};
    vecs[1]  = '{1'b0, 1'b1, 2'd2, 17'h00200, 32'hDEADBEEF, 32'h0,        5};
    vecs[2]  = '{1'b0, 1'b0, 2'd1, 17'h00202, 32'h0,        32'h0000DEAD, 4};
    vecs[3]  = '{1'b0, 1'b0, 2'd0, 17'h00200, 32'h0,        32'h000000EF, 3};
    vecs[4]  = '{1'b0, 1'b0, 2'd2, 17'h00200, 32'h0,        32'hDEADBEEF, 6};
    vecs[5]  = '{1'b0, 1'b1, 2'd3, 17'h1FFFE, 32'h44332211, 32'h0,        5};
    vecs[6]  = '{1'b0, 1'b0, 2'd2, 17'h1FFFE, 32'h0,        32'h44332211, 6};
    vecs[7]  = '{1'b0, 1'b0, 2'd1, 17'h1FFFF, 32'h0,        32'h00003322, 4};
    vecs[8]  = '{1'b1, 1'b0, 2'd2, 17'h1FFFE, 32'h0,        32'h44332211, 6};
    vecs[9]  = '{1'b0, 1'b1, 2'd0, 17'h00300, 32'h12345678, 32'h0,        2};
    vecs[10] = '{1'b0, 1'b0, 2'd3, 17'h00300, 32'h0,        32'h00000078, 6};
    vecs[11] = '{1'b0, 1'b1, 2'd1, 17'h00010, 32'hAAAA007F, 32'h0,        3};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_if_data", if_data, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    check("rst_ctl", {27'd0, ram_wr, busy, if_done, mem_done, 1'b0}, 32'h0);
    check("rst_ram_dout", 32'(ram_dout), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].is_if, vecs[i].we, vecs[i].len, vecs[i].addr, vecs[i].wdata, rd, edges);
      if (vecs[i].is_if || !vecs[i].we)
        check($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
      else
        model_write(vecs[i].addr, nbytes(vecs[i].len), vecs[i].wdata);
      check($sformatf("vec%0d_latency", i), 32'(edges), 32'(vecs[i].exp_edges));
    end
    check("wrap_byte0", 32'(ram[0]), 32'h33);
    check("wrap_byte1", 32'(ram[1]), 32'h44);

    // Simultaneous requests: MEM first, IF granted the edge after mem_done
    snap = if_done_cnt;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 17'h10;
    if_req = 1'b1; if_addr = 17'h100;
    edges = 0;
    while (edges < 40) begin
      @(posedge clk); edges++; @(negedge clk);
      if (mem_done) break;
    end
    check("arb_mem_latency", 32'(edges), 32'd3);
    check("arb_mem_rdata", mem_rdata, 32'h0000007F);
    check("arb_no_if_yet", 32'(if_done_cnt - snap), 32'd0);
    mem_req = 1'b0;
    edges = 0;
    while (edges < 40) begin
      @(posedge clk); edges++; @(negedge clk);
      if (if_done) break;
    end
    check("arb_if_latency", 32'(edges), 32'd6);
    check("arb_if_data", if_data, 32'h03020100);
    if_req = 1'b0;
    @(negedge clk);

    // IF flush two cycles into the fetch
    snap = if_done_cnt;
    if_req = 1'b1; if_addr = 17'h200;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    check("flush_busy_before", 32'(busy), 32'd1);
    if_req = 1'b0;
    @(posedge clk); @(negedge clk);
    check("flush_busy_after", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("flush_no_done", 32'(if_done_cnt - snap), 32'd0);
    check("flush_if_data_kept", if_data, 32'h03020100);
    run_op(1'b1, 1'b0, 2'd2, 17'h200, 32'h0, rd, edges);
    check("refetch_data", rd, 32'hDEADBEEF);
    check("refetch_latency", 32'(edges), 32'd6);

    // Reset in the middle of a word store
    snap = mem_done_cnt;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2; mem_addr = 17'h400; mem_wdata = 32'hCAFEF00D;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    check("midwr_wr_active", 32'(ram_wr), 32'd1);
    rst = 1'b0;
    #1;
    check("midwr_ram_wr", 32'(ram_wr), 32'd0);
    check("midwr_busy", 32'(busy), 32'd0);
    check("midwr_ram_addr", 32'(ram_addr), 32'd0);
    check("midwr_outs", if_data | mem_rdata | 32'(ram_dout), 32'd0);
    mem_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midwr_no_done", 32'(mem_done_cnt - snap), 32'd0);
    check("midwr_byte2_untouched", 32'(ram[17'h402]), 32'h0);
    for (int k = 0; k < 4; k++) shadow[17'h400 + k] = ram[17'h400 + k];

    // Random traffic against the reference memory image
    for (int i = 0; i < 80; i++) begin
      logic          r_if, r_we;
      logic [1:0]    r_len;
      logic [AW-1:0] r_addr;
      logic [31:0]   r_wd;
      int            n;
      r_if  = ($urandom_range(0, 3) == 0);
      r_we  = r_if ? 1'b0 : 1'($urandom_range(0, 1));
      r_len = 2'($urandom_range(0, 3));
      r_addr = ($urandom_range(0, 3) == 0) ? AW'(17'h1FFFC + $urandom_range(0, 3))
                                           : AW'(17'h500 + $urandom_range(0, 15));
      r_wd  = $urandom;
      n     = r_if ? 4 : nbytes(r_len);
      run_op(r_if, r_we, r_len, r_addr, r_wd, rd, edges);
      if (r_we) begin
        model_write(r_addr, n, r_wd);
        check($sformatf("rnd%0d_wr_latency", i), 32'(edges), 32'(n + 1));
      end else begin
        check($sformatf("rnd%0d_rd_data", i), rd, model_read(r_addr, n));
        check($sformatf("rnd%0d_rd_latency", i), 32'(edges), 32'(n + 2));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
